maxpool2: RTL and testbench

- Pooling stage directly downstream of the 2D convolution stage; consumes its (SIZE x SIZE) signed feature map once the conv stage pulses done.
- Snapshots the map and computes a POOL x POOL, stride-POOL max-pool sequentially, one element compared per cycle.
- Optionally applies ReLU, and presents an OUT x OUT pooled map with a one-cycle done pulse.

---
 rtl/maxpool2.sv | 129 ++++++++++++
 tb/tb_maxpool2.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2.sv
// Sequential POOL x POOL / stride-POOL max-pool over a snapshot of the conv feature map.
// One element is compared per clock; optional ReLU on each pooled result; done pulses once per pass.
module maxpool2 #(
    parameter  int SIZE      = 5,
    parameter  int POOL      = 2,
    parameter  int WIDTH_BIT = 8,
    parameter  int RELU      = 1,
    localparam int OUT       = SIZE / POOL
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        start,
    input  logic signed [WIDTH_BIT-1:0] inpMatrix [SIZE-1:0][SIZE-1:0],
    output logic                        busy,
    output logic                        done,
    output logic signed [WIDTH_BIT-1:0] pooledOut [OUT-1:0][OUT-1:0],
    output logic [1:0]                  o_dbg_state
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

    state_t                        r_state;
    logic signed [WIDTH_BIT-1:0]   r_snap [SIZE-1:0][SIZE-1:0];
    logic [OW-1:0]                 r_row;
    logic [OW-1:0]                 r_col;
    logic [PW-1:0]                 r_wr;
    logic [PW-1:0]                 r_wc;
    logic signed [WIDTH_BIT-1:0]   r_max;

    logic [IW-1:0]                 w_srow;
    logic [IW-1:0]                 w_scol;
    logic signed [WIDTH_BIT-1:0]   w_elem;
    logic signed [WIDTH_BIT-1:0]   w_max;
    logic signed [WIDTH_BIT-1:0]   w_res;
    logic                          w_first;
    logic                          w_wc_last;
    logic                          w_wr_last;
    logic                          w_col_last;
    logic                          w_row_last;

    assign o_dbg_state = r_state;

    // Window element address, running-max update and ReLU for the element read this cycle.
    always_comb begin
        w_srow     = IW'(int'(r_row) * POOL + int'(r_wr));
        w_scol     = IW'(int'(r_col) * POOL + int'(r_wc));
        w_elem     = r_snap[w_srow][w_scol];
        w_first    = (r_wr == '0) && (r_wc == '0);
        w_max      = (w_first || (w_elem > r_max)) ? w_elem : r_max;
        w_res      = ((RELU != 0) && w_max[WIDTH_BIT-1]) ? '0 : w_max;
        w_wc_last  = (r_wc == PW'(POOL - 1));
        w_wr_last  = (r_wr == PW'(POOL - 1));
        w_col_last = (r_col == OW'(OUT - 1));
        w_row_last = (r_row == OW'(OUT - 1));
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_wr    <= '0;
            r_wc    <= '0;
            r_max   <= '0;
            for (int i = 0; i < SIZE; i++)
                for (int j = 0; j < SIZE; j++)
                    r_snap[i][j] <= '0;
            for (int i = 0; i < OUT; i++)
                for (int j = 0; j < OUT; j++)
                    pooledOut[i][j] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_snap  <= inpMatrix;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_wr    <= '0;
                        r_wc    <= '0;
                        r_max   <= '0;
                        busy    <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_max <= w_max;
                    if (w_wc_last && w_wr_last)
                        pooledOut[r_row][r_col] <= w_res;
                    // Counter nest: wc fastest, then wr, col, row.
                    if (!w_wc_last) begin
                        r_wc <= r_wc + PW'(1);
                    end else begin
                        r_wc <= '0;
                        if (!w_wr_last) begin
                            r_wr <= r_wr + PW'(1);
                        end else begin
                            r_wr <= '0;
                            if (!w_col_last) begin
                                r_col <= r_col + OW'(1);
                            end else begin
                                r_col <= '0;
                                if (!w_row_last) begin
                                    r_row <= r_row + OW'(1);
                                end else begin
                                    r_row   <= '0;
                                    r_state <= FIN;
                                end
                            end
                        end
                    end
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool2.sv
// Bench for maxpool2: RELU=1 and RELU=0 instances share stimulus; a done-triggered
// monitor pops expected maps and done cycles from queues filled by the driver.
module tb_maxpool2;

    localparam int SIZE = 5;
    localparam int POOL = 2;
    localparam int W    = 8;
    localparam int OUT  = 2;
    localparam int LAT  = 17;
    localparam int MW   = W * OUT * OUT;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    logic start  = 1'b0;
    logic signed [W-1:0] in_m [SIZE-1:0][SIZE-1:0];

    logic busy1, done1, busy0, done0;
    logic signed [W-1:0] p1 [OUT-1:0][OUT-1:0];
    logic signed [W-1:0] p0 [OUT-1:0][OUT-1:0];
    logic [1:0] dbg1, dbg0;

    maxpool2 #(.SIZE(SIZE), .POOL(POOL), .WIDTH_BIT(W), .RELU(1)) dut1 (
        .clock(clock), .nreset(nreset), .start(start), .inpMatrix(in_m),
        .busy(busy1), .done(done1), .pooledOut(p1), .o_dbg_state(dbg1)
    );

    maxpool2 #(.SIZE(SIZE), .POOL(POOL), .WIDTH_BIT(W), .RELU(0)) dut0 (
        .clock(clock), .nreset(nreset), .start(start), .inpMatrix(in_m),
        .busy(busy0), .done(done0), .pooledOut(p0), .o_dbg_state(dbg0)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [MW-1:0] exp1_q[$];
    logic [MW-1:0] exp0_q[$];
    int            exp_cyc_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [MW-1:0] pack(input logic signed [W-1:0] p [OUT-1:0][OUT-1:0]);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++)
                v[(r*OUT+c)*W +: W] = p[r][c];
        return v;
    endfunction

    // a=[0][0], b=[0][1], c=[1][0], d=[1][1]
    function automatic logic [MW-1:0] mk4(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Reference max-pool over a full map, straight from the definition.
    function automatic logic [MW-1:0] pool_model(input logic signed [W-1:0] m [SIZE-1:0][SIZE-1:0],
                                                 input bit relu);
        logic [MW-1:0] v;
        logic signed [W-1:0] best;
        v = '0;
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++) begin
                best = m[r*POOL][c*POOL];
                for (int a = 0; a < POOL; a++)
                    for (int b = 0; b < POOL; b++)
                        if (m[r*POOL+a][c*POOL+b] > best) best = m[r*POOL+a][c*POOL+b];
                if (relu && best < 0) best = '0;
                v[(r*OUT+c)*W +: W] = best;
            end
        return v;
    endfunction

    int            m_ec;
    logic [MW-1:0] m_e1, m_e0;

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (nreset && (done1 || done0)) begin
            if (exp_cyc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d required no done", cyc);
            end else begin
                m_ec = exp_cyc_q.pop_front();
                m_e1 = exp1_q.pop_front();
                m_e0 = exp0_q.pop_front();
                chk("done_cycle", cyc, m_ec);
                chk("done_both", {30'd0, done1, done0}, 32'd3);
                chk("busy_at_done", {30'd0, busy1, busy0}, 32'd0);
                chk("pool_relu1", pack(p1), m_e1);
                chk("pool_relu0", pack(p0), m_e0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_all(input int v);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                in_m[i][j] = W'(v);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                in_m[i][j] = W'(i * 5 + j);
    endtask

    // Called at a negedge: start is sampled at the next posedge.
    task automatic launch_now(input logic [MW-1:0] e1, input logic [MW-1:0] e0);
        start = 1'b1;
        exp_cyc_q.push_back(cyc + 1 + LAT);
        exp1_q.push_back(e1);
        exp0_q.push_back(e0);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", {30'd0, busy1, busy0}, 32'd3);
    endtask

    task automatic launch(input logic [MW-1:0] e1, input logic [MW-1:0] e0);
        @(negedge clock);
        launch_now(e1, e0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_cyc_q.size() != 0 || busy1 || busy0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_cyc_q.size() != 0 || busy1 || busy0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending after %0d cycles required 0", exp_cyc_q.size(), budget);
            exp_cyc_q.delete();
            exp1_q.delete();
            exp0_q.delete();
        end
    endtask

    int img [7][7];
    int kern [3][3];
    logic signed [W-1:0] conv_m [SIZE-1:0][SIZE-1:0];

    // Stands in for the conv stage: 5x5 valid convolution, then start acts as its done.
    task automatic conv_pass(input int seed);
        int s;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                img[i][j] = ((i * 3 + j * 5 + seed) % 5) - 2;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                kern[a][b] = ((a * 2 + b + seed) % 3) - 1;
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) begin
                s = 0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        s += img[i+a][j+b] * kern[a][b];
                conv_m[i][j] = W'(s);
            end
        @(negedge clock);
        in_m = conv_m;
        launch_now(pool_model(conv_m, 1'b1), pool_model(conv_m, 1'b0));
        wait_drain(40);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        set_all(0);
        #12;
        chk("reset_busy", {30'd0, busy1, busy0}, 32'd0);
        chk("reset_done", {30'd0, done1, done0}, 32'd0);
        chk("reset_pool1", pack(p1), '0);
        chk("reset_pool0", pack(p0), '0);
        chk("reset_state", {28'd0, dbg1, dbg0}, 32'd0);
        @(negedge clock);
        nreset = 1'b1;

        // Ramp 0..24: row 4 / col 4 (e.g. 24) must never be selected.
        set_ramp();
        launch(mk4(6, 8, 16, 18), mk4(6, 8, 16, 18));
        wait_drain(40);

        // Signed values with and without ReLU.
        set_all(-3);
        in_m[1][1] = -8'sd1;
        launch(mk4(0, 0, 0, 0), mk4(-1, -3, -3, -3));
        wait_drain(40);

        // Most negative value as first element and as window max.
        set_all(-128);
        in_m[0][1] = -8'sd127;
        launch(mk4(0, 0, 0, 0), mk4(-127, -128, -128, -128));
        wait_drain(40);

        // Snapshot isolation: input changes right after start.
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++)
                in_m[i][j] = W'(24 - (i * 5 + j));
        launch(mk4(24, 22, 14, 12), mk4(24, 22, 14, 12));
        set_all(100);
        wait_drain(40);

        // Start during SCAN is ignored; a start right after done launches a second pass.
        set_ramp();
        launch(mk4(6, 8, 16, 18), mk4(6, 8, 16, 18));
        repeat (4) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!done1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        set_all(-3);
        in_m[1][1] = -8'sd1;
        launch_now(mk4(0, 0, 0, 0), mk4(-1, -3, -3, -3));
        wait_drain(40);

        // Ramp pass aborted by reset mid-SCAN; no done may follow.
        set_ramp();
        launch(mk4(6, 8, 16, 18), mk4(6, 8, 16, 18));
        repeat (4) @(negedge clock);
        #2 nreset = 1'b0;
        #1;
        exp_cyc_q.delete();
        exp1_q.delete();
        exp0_q.delete();
        chk("abort_busy", {30'd0, busy1, busy0}, 32'd0);
        chk("abort_done", {30'd0, done1, done0}, 32'd0);
        chk("abort_pool1", pack(p1), '0);
        chk("abort_pool0", pack(p0), '0);
        chk("abort_state", {28'd0, dbg1, dbg0}, 32'd0);
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        repeat (25) @(negedge clock);

        // Chained behind an emulated conv stage, two conv results.
        conv_pass(0);
        conv_pass(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
